// File: rtl/horizontal_tf_sequencer.sv
// Start/busy/done sequencer for the horizontal twiddle-factor datapath: slot, order and group
// counters, operand source select, and the ROM write strobe aligned to the multiplier latency.
module horizontal_tf_sequencer #(
    parameter int MUL_LAT  = 4,
    parameter int SC_WIDTH = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [SC_WIDTH-1:0] stage_counter,
    input  logic                CEN,
    output logic                busy,
    output logic                done,
    output logic                abort,
    output logic [1:0]          slot_cnt,
    output logic [1:0]          tf_order,
    output logic [3:0]          group_cnt,
    output logic                src_sel,
    output logic                const_cap_en,
    output logic                issue_valid,
    output logic                wr_en,
    output logic [1:0]          wr_slot
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        PRIME = 3'd1,
        RUN   = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam logic [4:0] DRAIN_LAST = 5'(MUL_LAT - 1);

    state_t     state;
    state_t     state_nxt;
    logic [4:0] drain_cnt;
    logic       stage_ok;
    logic       abort_req;
    logic       last_issue;
    logic [2:0] wr_pipe [MUL_LAT];

    assign stage_ok   = (stage_counter == '0);
    assign abort_req  = ((state == PRIME) || (state == RUN) || (state == DRAIN)) && !stage_ok;
    assign last_issue = issue_valid && (tf_order == 2'd3) && (slot_cnt == 2'd3);

    always_comb begin
        state_nxt   = state;
        issue_valid = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        case (state)
            IDLE: begin
                if (start && stage_ok && !CEN)
                    state_nxt = PRIME;
            end
            PRIME: begin
                busy      = 1'b1;
                state_nxt = RUN;
            end
            RUN: begin
                busy        = 1'b1;
                issue_valid = !CEN;
                if (last_issue)
                    state_nxt = DRAIN;
            end
            DRAIN: begin
                busy = 1'b1;
                if (drain_cnt == DRAIN_LAST)
                    state_nxt = DONE;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        // A stage change cancels the block, even on the cycle it would have completed.
        if (abort_req)
            state_nxt = IDLE;
    end

    assign src_sel      = (tf_order != 2'd0);
    assign const_cap_en = issue_valid && (group_cnt == 4'd0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            abort     <= 1'b0;
            drain_cnt <= '0;
        end else begin
            state     <= state_nxt;
            abort     <= abort_req;
            drain_cnt <= (state == DRAIN) ? drain_cnt + 5'd1 : 5'd0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_cnt  <= '0;
            tf_order  <= '0;
            group_cnt <= '0;
        end else if (abort_req || (state == DONE)) begin
            slot_cnt  <= '0;
            tf_order  <= '0;
            group_cnt <= '0;
        end else if (issue_valid) begin
            slot_cnt  <= slot_cnt + 2'd1;
            group_cnt <= group_cnt + 4'd1;
            if (slot_cnt == 2'd3)
                tf_order <= tf_order + 2'd1;
        end
    end

    // Write delay line: {issue_valid, slot_cnt} re-emerges MUL_LAT cycles later with the product.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < MUL_LAT; i++)
                wr_pipe[i] <= '0;
        end else if (abort_req) begin
            for (int i = 0; i < MUL_LAT; i++)
                wr_pipe[i] <= '0;
        end else begin
            wr_pipe[0] <= {issue_valid, slot_cnt};
            for (int i = 1; i < MUL_LAT; i++)
                wr_pipe[i] <= wr_pipe[i-1];
        end
    end

    assign wr_en   = wr_pipe[MUL_LAT-1][2];
    assign wr_slot = wr_pipe[MUL_LAT-1][1:0];

endmodule

// File: tb/tb_horizontal_tf_sequencer.sv
// Directed bench for horizontal_tf_sequencer: one instance at MUL_LAT=4 for the full checks,
// plus MUL_LAT=1/7/16 instances sharing the stimulus for the latency sweep.
module tb_horizontal_tf_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [3:0] stage_counter;
    logic       CEN;

    logic       busy, done, abort, src_sel, const_cap_en, issue_valid, wr_en;
    logic [1:0] slot_cnt, tf_order, wr_slot;
    logic [3:0] group_cnt;

    logic       s_busy [3], s_done [3], s_abort [3], s_src [3], s_cap [3], s_iss [3], s_wr [3];
    logic [1:0] s_slot [3], s_tf [3], s_wslot [3];
    logic [3:0] s_grp [3];

    int checks = 0;
    int errors = 0;
    int lat [4] = '{4, 1, 7, 16};

    always #5 clk = ~clk;

    horizontal_tf_sequencer #(.MUL_LAT(4), .SC_WIDTH(4)) u0 (
        .clk(clk), .rst(rst), .start(start), .stage_counter(stage_counter), .CEN(CEN),
        .busy(busy), .done(done), .abort(abort), .slot_cnt(slot_cnt), .tf_order(tf_order),
        .group_cnt(group_cnt), .src_sel(src_sel), .const_cap_en(const_cap_en),
        .issue_valid(issue_valid), .wr_en(wr_en), .wr_slot(wr_slot)
    );

    horizontal_tf_sequencer #(.MUL_LAT(1), .SC_WIDTH(4)) u1 (
        .clk(clk), .rst(rst), .start(start), .stage_counter(stage_counter), .CEN(CEN),
        .busy(s_busy[0]), .done(s_done[0]), .abort(s_abort[0]), .slot_cnt(s_slot[0]),
        .tf_order(s_tf[0]), .group_cnt(s_grp[0]), .src_sel(s_src[0]), .const_cap_en(s_cap[0]),
        .issue_valid(s_iss[0]), .wr_en(s_wr[0]), .wr_slot(s_wslot[0])
    );

    horizontal_tf_sequencer #(.MUL_LAT(7), .SC_WIDTH(4)) u7 (
        .clk(clk), .rst(rst), .start(start), .stage_counter(stage_counter), .CEN(CEN),
        .busy(s_busy[1]), .done(s_done[1]), .abort(s_abort[1]), .slot_cnt(s_slot[1]),
        .tf_order(s_tf[1]), .group_cnt(s_grp[1]), .src_sel(s_src[1]), .const_cap_en(s_cap[1]),
        .issue_valid(s_iss[1]), .wr_en(s_wr[1]), .wr_slot(s_wslot[1])
    );

    horizontal_tf_sequencer #(.MUL_LAT(16), .SC_WIDTH(4)) u16 (
        .clk(clk), .rst(rst), .start(start), .stage_counter(stage_counter), .CEN(CEN),
        .busy(s_busy[2]), .done(s_done[2]), .abort(s_abort[2]), .slot_cnt(s_slot[2]),
        .tf_order(s_tf[2]), .group_cnt(s_grp[2]), .src_sel(s_src[2]), .const_cap_en(s_cap[2]),
        .issue_valid(s_iss[2]), .wr_en(s_wr[2]), .wr_slot(s_wslot[2])
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Drive one cycle's inputs mid-cycle, then settle so outputs of that cycle can be sampled.
    task automatic cyc(input logic s, input logic cen, input logic [3:0] sc);
        @(negedge clk);
        start         = s;
        CEN           = cen;
        stage_counter = sc;
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " busy"}, busy, 0);
        chk({tag, " done"}, done, 0);
        chk({tag, " abort"}, abort, 0);
        chk({tag, " issue"}, issue_valid, 0);
        chk({tag, " wr_en"}, wr_en, 0);
        chk({tag, " wr_slot"}, wr_slot, 0);
        chk({tag, " slot"}, slot_cnt, 0);
        chk({tag, " tf"}, tf_order, 0);
        chk({tag, " grp"}, group_cnt, 0);
        chk({tag, " src"}, src_sel, 0);
        chk({tag, " cap"}, const_cap_en, 0);
    endtask

    initial begin
        int first_wr [4];
        int done_at  [4];
        int wr_count;
        int done_cnt;
        int k;
        int l;
        logic iss;
        logic [3:0] wr_vec;
        logic [3:0] done_vec;
        logic [3:0] busy_vec;

        rst = 1'b1;
        start = 1'b0;
        CEN = 1'b0;
        stage_counter = '0;
        cyc(0, 0, 0);
        cyc(0, 0, 0);
        chk_all_zero("reset");
        rst = 1'b0;
        cyc(0, 0, 0);
        cyc(0, 0, 0);

        // Nominal run, all latencies together.
        for (int d = 0; d < 4; d++) begin
            first_wr[d] = -1;
            done_at[d]  = -1;
        end
        for (int c = 0; c <= 36; c++) begin
            cyc(c == 0, 0, 0);
            iss = (c >= 2) && (c <= 17);
            k = c - 2;
            chk($sformatf("nom c%0d issue", c), issue_valid, iss);
            chk($sformatf("nom c%0d slot", c), slot_cnt, iss ? k % 4 : 0);
            chk($sformatf("nom c%0d tf", c), tf_order, iss ? k / 4 : 0);
            chk($sformatf("nom c%0d grp", c), group_cnt, iss ? k : 0);
            chk($sformatf("nom c%0d src", c), src_sel, iss && (k >= 4));
            chk($sformatf("nom c%0d cap", c), const_cap_en, c == 2);
            chk($sformatf("nom c%0d abort", c), abort, 0);
            chk($sformatf("nom c%0d wr_slot", c), wr_slot,
                ((c >= 6) && (c <= 21)) ? (c - 6) % 4 : 0);
            wr_vec   = {s_wr[2], s_wr[1], s_wr[0], wr_en};
            done_vec = {s_done[2], s_done[1], s_done[0], done};
            busy_vec = {s_busy[2], s_busy[1], s_busy[0], busy};
            for (int d = 0; d < 4; d++) begin
                l = lat[d];
                chk($sformatf("nom L%0d c%0d wr_en", l, c), wr_vec[d], (c >= 2 + l) && (c <= 17 + l));
                chk($sformatf("nom L%0d c%0d done", l, c), done_vec[d], c == 18 + l);
                chk($sformatf("nom L%0d c%0d busy", l, c), busy_vec[d], (c >= 1) && (c <= 17 + l));
                if (wr_vec[d] && first_wr[d] < 0) first_wr[d] = c;
                if (done_vec[d]) done_at[d] = c;
            end
        end
        for (int d = 0; d < 4; d++) begin
            chk($sformatf("sweep L%0d first wr_en", lat[d]), first_wr[d], 2 + lat[d]);
            chk($sformatf("sweep L%0d done cycle", lat[d]), done_at[d], 18 + lat[d]);
        end

        // Pause: CEN high in cycles 5 and 6.
        wr_count = 0;
        done_at[0] = -1;
        for (int c = 0; c <= 30; c++) begin
            cyc(c == 0, (c == 5) || (c == 6), 0);
            if (wr_en) wr_count++;
            if (done) done_at[0] = c;
            if (c == 5 || c == 6) begin
                chk($sformatf("pause c%0d issue", c), issue_valid, 0);
                chk($sformatf("pause c%0d slot", c), slot_cnt, 3);
                chk($sformatf("pause c%0d grp", c), group_cnt, 3);
            end
            if (c == 7) chk("pause c7 slot", slot_cnt, 3);
            if (c == 8) chk("pause c8 wr_en", wr_en, 1);
            if (c == 9 || c == 10) chk($sformatf("pause c%0d wr_en", c), wr_en, 0);
            if (c == 11) chk("pause c11 wr_en", wr_en, 1);
        end
        chk("pause wr_en count", wr_count, 16);
        chk("pause done cycle", done_at[0], 24);

        // Abort: stage_counter leaves 0 in cycle 8.
        done_cnt = 0;
        for (int c = 0; c <= 30; c++) begin
            cyc(c == 0, 0, (c == 8) ? 4'd1 : 4'd0);
            if (done) done_cnt++;
            if (c == 9) begin
                chk("abort c9 abort", abort, 1);
                chk("abort c9 busy", busy, 0);
                chk("abort c9 slot", slot_cnt, 0);
                chk("abort c9 tf", tf_order, 0);
                chk("abort c9 grp", group_cnt, 0);
            end
            if (c == 10) chk("abort c10 abort", abort, 0);
            if (c >= 9) chk($sformatf("abort c%0d wr_en", c), wr_en, 0);
        end
        chk("abort done count", done_cnt, 0);

        // Gating: start blocked by CEN or a nonzero stage.
        cyc(1, 1, 0);
        cyc(0, 0, 0);
        chk("gate cen busy", busy, 0);
        cyc(0, 0, 0);
        chk("gate cen busy2", busy, 0);
        cyc(1, 0, 2);
        cyc(0, 0, 0);
        chk("gate stage busy", busy, 0);
        cyc(0, 0, 0);

        // Start while busy and in DONE ignored; restart the cycle after DONE accepted.
        done_cnt = 0;
        done_at[0] = -1;
        for (int c = 0; c <= 50; c++) begin
            cyc((c == 0) || (c == 10) || (c == 22) || (c == 23), 0, 0);
            if (done) begin
                done_cnt++;
                if (done_cnt == 1) done_at[0] = c;
            end
            if (c == 23) chk("restart c23 busy", busy, 0);
            if (c == 24) chk("restart c24 busy", busy, 1);
            if (c == 45) chk("restart c45 done", done, 1);
        end
        chk("restart first done", done_at[0], 22);
        chk("restart done count", done_cnt, 2);

        // Asynchronous reset mid-run.
        for (int c = 0; c <= 11; c++) cyc(c == 0, 0, 0);
        chk("rstmid c11 issue", issue_valid, 1);
        cyc(0, 0, 0);
        rst = 1'b1;
        #1;
        chk_all_zero("rstmid");
        cyc(0, 0, 0);
        rst = 1'b0;
        cyc(0, 0, 0);
        done_at[0] = -1;
        for (int c = 0; c <= 24; c++) begin
            cyc(c == 0, 0, 0);
            if (done) done_at[0] = c;
        end
        chk("post-reset done cycle", done_at[0], 22);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/horizontal_tf_sequencer.md
# horizontal_tf_sequencer

Sequencing controller for the horizontal twiddle-factor datapath in the R16 16384-point pipeline. It runs the per-block slot, twiddle-order and group counters, and selects base or feedback operands for the difference-ROM multipliers. It also drives the FIFO mode and times the processed-twiddle ROM writes to the modular-multiplier latency. It replaces the free-running counters with a start/busy/done FSM that supports pause (CEN) and abort.

## Interface
- MUL_LAT, 4, MulMod128 pipeline latency in cycles; legal 1..16
- SC_WIDTH, 4, width of stage_counter
- clk  input  1  rising-edge clock
- rst  input  1  reset; one clock; asynchronous, active-high
- start  input  1  single-cycle request to process one 16-cycle block
- stage_counter  input  SC_WIDTH  current stage; the block runs only while it is 0
- CEN  input  1  active-low enable; 1 pauses issue
- busy  output  1  high from PRIME through DRAIN
- done  output  1  one-cycle pulse on normal completion
- abort  output  1  one-cycle pulse when a run is cancelled
- slot_cnt  output  2  operand slot 0..3 within a twiddle order
- tf_order  output  2  twiddle order 0..3; also the FIFO mode
- group_cnt  output  4  group index 0..15
- src_sel  output  1  0 selects the row base value, 1 selects the delayed multiplier feedback
- const_cap_en  output  1  load strobe for the shared row-0 constant register
- issue_valid  output  1  operand pair presented to the multipliers this cycle
- wr_en  output  1  issue_valid delayed by MUL_LAT cycles; strobes the ROM write
- wr_slot  output  2  slot_cnt delayed by MUL_LAT cycles; selects the ROM write lane

## Operation
- States: IDLE, PRIME, RUN, DRAIN, DONE.
- IDLE to PRIME on start && stage_counter==0 && !CEN. Otherwise start is ignored and produces no response.
- PRIME lasts one cycle and matches the CEN register delay in the datapath. PRIME goes to RUN.
- RUN, when !CEN:
  - issue_valid=1.
  - slot_cnt increments and wraps 3→0.
  - tf_order increments when slot_cnt==3.
  - group_cnt increments and wraps 15→0.
- RUN with CEN=1: all counters hold and issue_valid=0. The write delay line keeps shifting.
- RUN ends after the issue with tf_order==3 && slot_cnt==3, which is the 16th issue. RUN then goes to DRAIN.
- DRAIN counts MUL_LAT cycles, then goes to DONE.
- DONE lasts one cycle: done=1, then IDLE. The counters clear to 0 on entry to IDLE.
- Combinational outputs:
  - src_sel = (tf_order != 0).
  - const_cap_en = issue_valid && group_cnt==0.
- The write path is a MUL_LAT-deep shift register of {issue_valid, slot_cnt}. Its output drives {wr_en, wr_slot}.
- Abort: stage_counter!=0 in PRIME, RUN or DRAIN.
  - Next cycle: state is IDLE and abort=1 for one cycle.
  - Counters and the delay line are cleared, so wr_en is 0 from the next cycle.
  - done is not asserted.
- start while busy is ignored.
- Abort takes priority over completion in the same cycle.

## Timing
- Reset values: state IDLE, every output 0, delay line cleared. Reset asserted mid-run takes effect immediately (asynchronous).
- Without pauses, with start sampled at cycle 0:
  - PRIME at cycle 1.
  - issue_valid high in cycles 2..17.
  - wr_en high in cycles 2+MUL_LAT..17+MUL_LAT.
  - done high in cycle 18+MUL_LAT.
  - busy high in cycles 1..17+MUL_LAT.
- Each cycle with CEN=1 during RUN delays the remaining issues and done by one cycle.
- A CEN=1 cycle produces exactly one wr_en=0 gap, MUL_LAT cycles later.
- CEN has no effect in PRIME, DRAIN or DONE.
- A start in the DONE cycle is ignored. The earliest accepted restart is the IDLE cycle after DONE.

## Test plan
- Nominal, MUL_LAT=4, start at cycle 0, CEN=0 → 16 issues in cycles 2..17:
  - slot_cnt runs 0,1,2,3 four times; tf_order steps 0→3.
  - src_sel=0 only for issues 1..4; const_cap_en only at cycle 2.
  - wr_en high 6..21 with wr_slot 0,1,2,3…; done at cycle 22.
- Pause: CEN=1 in cycles 5 and 6 → counters frozen over those two cycles, wr_en low in cycles 9 and 10, done at cycle 24, total of 16 wr_en pulses.
- Abort: stage_counter=1 in cycle 8 → abort in cycle 9, busy=0 and counters 0 in cycle 9, no wr_en from cycle 9, no done.
- Gating: start with CEN=1 or stage_counter=2 → no response; start in cycle 10 of an active run → ignored, completion unchanged.
- Reset: assert rst in cycle 12 of a run → all outputs 0 immediately; after release, a start completes normally.
- Latency sweep over MUL_LAT ∈ {1, 7, 16} → first wr_en at cycle 2+MUL_LAT, done at cycle 18+MUL_LAT.
